// File: rtl/trap_dump_monitor_pkg.sv
// Shared types and constants for the trap-triggered memory dump monitor.
// The trap encoding, dump base and word stride live here so the monitor and its bench agree on them.
package trap_dump_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DUMP  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] TRAP_WORD_DEF = 32'h4400_0300;
    localparam logic [31:0] DUMP_BASE_DEF = 32'd8192;
    localparam int unsigned WORD_STRIDE   = 32'd4;

endpackage

// File: rtl/trap_dump_monitor_if.sv
// Fetch observation, data-memory read port and dump stream of the monitor.
// slave is the monitor's view; master is the surrounding core / environment.
interface trap_dump_monitor_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic [31:0]       instr;
    logic              instr_valid;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              dump_valid;
    logic [15:0]       dump_index;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycle_count;

    modport slave (
        input  instr, instr_valid, mem_rd_data,
        output mem_rd_en, mem_rd_addr, dump_valid, dump_index, dump_addr,
               dump_data, busy, done, timed_out, cycle_count
    );

    modport master (
        output instr, instr_valid, mem_rd_data,
        input  mem_rd_en, mem_rd_addr, dump_valid, dump_index, dump_addr,
               dump_data, busy, done, timed_out, cycle_count
    );
endinterface

// File: rtl/trap_dump_monitor_sat_counter.sv
// Width-parametrised up-counter that sticks at all-ones and holds while freeze is high.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         freeze,
    output logic [W-1:0] count
);
    localparam logic [W-1:0] CNT_MAX = '1;

    // count up until saturation unless frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (srst) begin
            count <= '0;
        end else if (!freeze && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end
endmodule

// File: rtl/trap_dump_monitor.sv
// Watches the fetch stream for the end-of-program trap (or a cycle timeout) and then
// streams a fixed window of data memory out through the dump port, once per reset.
module trap_dump_monitor
    import trap_dump_pkg::*;
#(
    parameter int              DATA_W         = 32,
    parameter int              ADDR_W         = 32,
    parameter logic [31:0]     TRAP_WORD      = TRAP_WORD_DEF,
    parameter logic [ADDR_W-1:0] DUMP_BASE    = ADDR_W'(DUMP_BASE_DEF),
    parameter int unsigned     DUMP_WORDS     = 32'd10,
    parameter int unsigned     TIMEOUT_CYCLES = 32'd25000,
    parameter int              CNT_W          = 32
) (
    input  logic                clock,
    input  logic                reset,
    trap_dump_monitor_if.slave  bus
);
    localparam logic [CNT_W-1:0] TO_LAST  =
        CNT_W'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);
    localparam logic [15:0]      LAST_IDX =
        16'((DUMP_WORDS == 32'd0) ? 32'd0 : DUMP_WORDS - 32'd1);

    state_e              state_r;
    logic [15:0]         rd_idx_r;
    logic                mem_rd_en_r;
    logic [ADDR_W-1:0]   mem_rd_addr_r;
    logic                dump_valid_r;
    logic [15:0]         dump_index_r;
    logic [ADDR_W-1:0]   dump_addr_r;
    logic                busy_r;
    logic                done_r;
    logic                timed_out_r;
    logic [CNT_W-1:0]    cycle_count_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                trap_hit_s;
    logic                timeout_hit_s;
    logic                freeze_s;

    // trigger decode; a timeout of zero means the watchdog is disabled
    always_comb begin
        trap_hit_s = bus.instr_valid && (bus.instr == TRAP_WORD);
        if (TIMEOUT_CYCLES != 32'd0) begin
            timeout_hit_s = (cycle_count_s == TO_LAST);
        end else begin
            timeout_hit_s = 1'b0;
        end
        freeze_s = (state_r == ST_DONE);
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clock),
        .rst_n  (reset),
        .srst   (1'b0),
        .freeze (freeze_s),
        .count  (cycle_count_s)
    );

    // control FSM with read issue and registered dump sideband (one cycle behind the read)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_RUN;
            rd_idx_r      <= 16'd0;
            mem_rd_en_r   <= 1'b0;
            mem_rd_addr_r <= '0;
            dump_valid_r  <= 1'b0;
            dump_index_r  <= 16'd0;
            dump_addr_r   <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timed_out_r   <= 1'b0;
        end else begin
            dump_valid_r <= mem_rd_en_r;
            if (mem_rd_en_r) begin
                dump_index_r <= rd_idx_r;
                dump_addr_r  <= mem_rd_addr_r;
            end else begin
                dump_index_r <= dump_index_r;
                dump_addr_r  <= dump_addr_r;
            end

            case (state_r)
                ST_RUN: begin
                    if (trap_hit_s || timeout_hit_s) begin
                        // a trap in the same cycle as the timeout is a clean finish
                        timed_out_r <= !trap_hit_s;
                        if (DUMP_WORDS == 32'd0) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r       <= ST_DUMP;
                            busy_r        <= 1'b1;
                            mem_rd_en_r   <= 1'b1;
                            mem_rd_addr_r <= DUMP_BASE;
                            rd_idx_r      <= 16'd0;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DUMP: begin
                    if (rd_idx_r == LAST_IDX) begin
                        state_r     <= ST_DRAIN;
                        mem_rd_en_r <= 1'b0;
                    end else begin
                        rd_idx_r      <= rd_idx_r + 16'd1;
                        mem_rd_addr_r <= mem_rd_addr_r + ADDR_W'(WORD_STRIDE);
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r     <= ST_RUN;
                    mem_rd_en_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data_s       = bus.mem_rd_data;
    assign bus.mem_rd_en   = mem_rd_en_r;
    assign bus.mem_rd_addr = mem_rd_addr_r;
    assign bus.dump_valid  = dump_valid_r;
    assign bus.dump_index  = dump_index_r;
    assign bus.dump_addr   = dump_addr_r;
    assign bus.dump_data   = rd_data_s;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.timed_out   = timed_out_r;
    assign bus.cycle_count = cycle_count_s;
endmodule
